alu_seq_divider: RTL
====================

Name: alu_seq_divider

Overview:
- Multi-cycle signed divider that is the DIV (opcode 4'b1001) execution unit beside the 32-bit ALU.
- The ALU issues operands with a start pulse, waits for busy to drop and done to pulse, then consumes quotient and remainder into its result/remainder outputs.
- Radix-2 restoring algorithm on operand magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.
- Latency is fixed, so the ALU control counts nothing and keys only on done.

Parameters:
- N, 32, operand/result width in bits; legal values are N >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE; ignored while busy.
- dividend  input  N  signed dividend (ALU operand a). Sampled with start.
- divisor  input  N  signed divisor (ALU operand b). Sampled with start.
- busy  output  1  high from the cycle after start is accepted until done is asserted.
- done  output  1  one-cycle pulse; quotient, remainder and flags are valid from this cycle on.
- quotient  output  N  signed quotient, truncated toward zero.
- remainder  output  N  signed remainder; its sign follows the dividend.
- div_by_zero  output  1  sticky with the result: divisor was 0.
- overflow  output  1  sticky with the result: dividend = -2^(N-1) and divisor = -1.

Behaviour:
- Reset (asynchronous, any state, including mid-CALC):
  - state goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow are all 0.
  - the iteration counter is 0.
  - Any partial result is discarded.
- State machine:
  - IDLE: on start=1, latch |dividend| and |divisor| (each N-bit unsigned), the sign bits, the zero flag and the overflow flag. Clear the partial remainder, load the counter with N-1, set busy, go to CALC.
  - CALC, N cycles: each cycle, shift the partial remainder {R, Q-msb} left by 1 and trial-subtract the divisor magnitude (N+1-bit compare).
    - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
    - Decrement the counter; leave CALC when it reaches 0.
  - FIX, 1 cycle: negate the quotient magnitude if the sign bits differ, and negate the remainder magnitude if the dividend was negative. Load the output registers, go to DONE.
  - DONE, 1 cycle: done=1, busy=0, then go to IDLE. Outputs hold until the next accepted start reaches FIX.
- Latency: with start sampled at edge k, busy=1 from k, and done=1 in the cycle following edge k+N+2, which is edge k+34 for N=32.
  - A back-to-back start is accepted in the IDLE cycle after DONE; throughput is 1 op per N+3 cycles.
  - start asserted during DONE is ignored.
- Divide by zero:
  - The full latency is still used; there is no early exit.
  - Result is quotient = all ones (-1), remainder = dividend, div_by_zero = 1.
  - This falls out naturally from restoring division of the magnitude; the sign-fix for the quotient is suppressed.
- Overflow case (-2^(N-1) / -1):
  - Result is quotient = -2^(N-1) (bit pattern 1000…0), remainder = 0, overflow = 1.
  - Magnitude arithmetic must treat |-2^(N-1)| as the unsigned value 2^(N-1).
- Widths:
  - Magnitudes are N-bit unsigned.
  - The trial subtraction is N+1 bits so the carry decides the quotient bit.
  - Negation is two's complement modulo 2^N.
- div_by_zero and overflow are updated only in FIX; they remain valid with the result.
- Input changes on dividend or divisor after acceptance have no effect.

Decomposition:
- Shared package (alu_pkg):
  - the div state enum {IDLE, CALC, FIX, DONE} (2 bits).
  - the ALU opcode constants, including OP_DIV = 4'b1001 and OP_MUL = 4'b1000.
  - the default width constant ALU_W = 32.
- One natural sub-module: div_step. It is a combinational single restoring iteration: inputs are the partial remainder, the incoming bit and the divisor magnitude; outputs are the next remainder and the quotient bit. Instantiate it once inside the CALC datapath.
- The counter and FSM live in the top level.

Test Plan:
- Reset mid-op: start 100/7, assert rst at CALC cycle 10 -> busy=0 immediately (asynchronous); all outputs 0; done never pulses; a new start 9/3 then yields quotient=3, remainder=0.
- Basic and latency: start with 100 / 7 at edge k -> done pulse exactly at edge k+34, quotient=14, remainder=2, flags 0; busy high for 34 cycles.
- Signs: -100/7 -> quotient=-14, remainder=-2; 100/-7 -> quotient=-14, remainder=2; -100/-7 -> quotient=14, remainder=-2.
- Divide by zero: 7/0 -> quotient=0xFFFFFFFF, remainder=7, div_by_zero=1, latency 34.
- Overflow: 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1, div_by_zero=0.
- Handshake: pulse start again at cycles k+5 and k+34 -> both ignored. Start in the IDLE cycle after DONE (k+35) is accepted. 0x80000000/0x80000000 gives quotient=1, remainder=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, default datapath width and the divider FSM states.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/alu_seq_divider_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_dmag,
    output logic [N-1:0] o_rem,
    output logic         o_qbit
);

    logic [N+1:0] w_trial;

    // Extra top bit holds the borrow of the (N+1)-bit trial subtraction.
    assign w_trial = {1'b0, i_rem, i_bit} - {2'b00, i_dmag};
    assign o_qbit  = ~w_trial[N+1];
    assign o_rem   = o_qbit ? w_trial[N-1:0] : {i_rem[N-2:0], i_bit};

endmodule

// File: rtl/alu_seq_divider.sv
// Fixed-latency signed divider (DIV unit): restoring iteration on magnitudes plus a sign-fix cycle.
module alu_seq_divider
    import alu_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] dividend,
    input  logic signed [N-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] quotient,
    output logic signed [N-1:0] remainder,
    output logic                div_by_zero,
    output logic                overflow
);

    localparam int CW = $clog2(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    function automatic logic [N-1:0] neg2(input logic [N-1:0] v);
        return ~v + 1'b1;
    endfunction

    // |MIN_NEG| wraps back to the same bit pattern, read as unsigned 2^(N-1).
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
        return v[N-1] ? neg2(v) : v;
    endfunction

    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_dmag;
    logic             r_neg_dvd;
    logic             r_neg_dvs;
    logic             r_dz;
    logic             r_ov;

    logic [N-1:0]     w_rem_nxt;
    logic             w_qbit;

    div_step #(.N(N)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_q[N-1]),
        .i_dmag (r_dmag),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    // Datapath: r_q starts as the dividend magnitude and fills with quotient bits.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_rem     <= '0;
            r_q       <= magnitude(dividend);
            r_dmag    <= magnitude(divisor);
            r_neg_dvd <= dividend[N-1];
            r_neg_dvs <= divisor[N-1];
            r_dz      <= (divisor == '0);
            r_ov      <= ($unsigned(dividend) == MIN_NEG) && ($unsigned(divisor) == {N{1'b1}});
        end else if (r_state == CALC) begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[N-2:0], w_qbit};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        r_cnt   <= CW'(N - 1);
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // Divide-by-zero keeps the all-ones magnitude quotient unsigned-fixed.
                    quotient    <= $signed(((r_neg_dvd ^ r_neg_dvs) && !r_dz) ? neg2(r_q) : r_q);
                    remainder   <= $signed(r_neg_dvd ? neg2(r_rem) : r_rem);
                    div_by_zero <= r_dz;
                    overflow    <= r_ov;
                    r_state     <= DONE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
